snn_delay_layer: RTL and testbench
==================================

# snn_delay_layer

Parametrised leaky-integrate-and-fire spiking layer with per-synapse programmable axonal delays and refractory handling. It generalises the fixed two-layer delay network to arbitrary input count M, neuron count N and delay depth, and replaces the separate delay clock with a delay-tick enable in the single clock domain. Layers are cascaded by feeding one instance's `output_spikes` into the next instance's `input_spikes`.

## Interface
Parameters:
- `M`, 16: inputs (presynaptic spike lines).
- `N`, 8: neurons.
- `DW`, 3: delay-value width; max delay 2^DW-1 ticks.
- `PW`, 8: membrane potential, weight, threshold, decay and refractory width.

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: gates neuron integration and delay-line shifting.
- `delay_tick` in 1: delay-line shift strobe; qualified by `enable`.
- `input_spikes` in M: current presynaptic spikes.
- `weights` in N*M*PW: weight (n,m) is at `[(n*M+m)*PW +: PW]`.
- `delay_values` in N*M*DW: delay (n,m) is at `[(n*M+m)*DW +: DW]`.
- `delays_en` in N*M: bit (n*M+m) = 1 selects the delayed tap; 0 selects the undelayed input.
- `threshold`, `decay`, `refractory_period` in PW each: shared by all neurons.
- `membrane_potential_out` out N*PW: potential of neuron n at `[n*PW +: PW]`.
- `output_spikes` out N: registered, one-cycle spike pulses.

## Operation
- History: per input m, registers h[m][1..2^DW-1]; h[m][0] is combinationally `input_spikes[m]`. On an edge with `enable & delay_tick`: h[m][k] <= h[m][k-1] for k>=1. Without a tick, history holds.
- Effective spike s(n,m) = `delays_en`(n,m) ? h[m][`delay_values`(n,m)] : `input_spikes[m]`. Delay value 0 with the delay bit set is equivalent to undelayed.
- Per neuron, each edge with `enable`=1:
  - Refractory counter r>0: r <= r-1; potential held at 0; spike 0; inputs ignored.
  - Otherwise: acc = V + Σ_m s(n,m)·w(n,m) - decay.
    - acc is computed at width PW+clog2(M)+2, signed.
    - Clamp acc to [0, 2^PW-1].
    - If clamped >= threshold: spike=1, V<=0, r<=refractory_period.
    - Else: V <= clamped, spike=0.
- `enable`=0: V, r and history hold; `output_spikes` forced to 0 on that edge.
- Weights unsigned by default (see Configuration).

## Timing
- Reset values: V=0, r=0, all history 0, `output_spikes`=0, `membrane_potential_out`=0.
- Latency: an input spike at edge t, undelayed, appears in `membrane_potential_out` and `output_spikes` after edge t (1 cycle).
- Delayed tap d: the spike is present at `input_spikes` on the edge where the tick is taken, then contributes on the d-th subsequent `enable&delay_tick` edge's preceding cycle. Concretely, h[m][d] equals the input sampled d ticks earlier.
- Same-edge tick and integration: integration uses pre-shift history.
- A neuron with `refractory_period`=0 integrates again on the next enabled cycle after firing.
- `threshold`=0: a non-refractory neuron fires on every enabled cycle.
- Reset asserted mid-operation clears everything on that edge and overrides `enable`.
- Config inputs are sampled live every cycle; a change takes effect on the next edge.

## Configuration
- `SNN_SIGNED_WEIGHTS_EN` defined: weights are PW-bit two's complement and sign-extended into acc. Negative sums clamp V at 0. The potential itself stays unsigned.
- Not defined: weights are zero-extended, unsigned.

## Structure
- Package `snn_pkg`: `SNN_PW_DEFAULT`, `SNN_DW_DEFAULT`, the accumulator-width function, and a `snn_clamp` function shared by all neurons.
- Sub-module `snn_lif_neuron` (one per neuron, in a generate loop): takes the M effective spikes, M weights and the shared config; owns V, r and the spike register.
- The top owns the history registers and the tap muxing.

## Test plan
- Reset/idle: `reset`=1 for 2 cycles, then `enable`=1 with zero inputs and decay=1 -> all potentials 0, no spikes.
- Undelayed integration: M=16, N=8, threshold=10, decay=0, w(0,0)=4, `input_spikes[0]`=1 held -> V0 = 4, 8, then spike on the 3rd edge (12>=10), V0=0.
- Delay: `delays_en`(1,2)=1, `delay_values`(1,2)=3, w(1,2)=20, threshold=15, `delay_tick` every cycle, single-cycle spike on input 2 -> neuron 1 spikes exactly 3 ticks later, once.
- Refractory: refractory_period=2, input held after a spike -> 2 cycles with V=0 and no spike, then integration resumes.
- Saturation/decay: w=200 on two active inputs -> V clamps to 255. With inputs off and decay=100 -> V goes 155, 55, 0, 0.
- `SNN_SIGNED_WEIGHTS_EN` build: w=-5 (0xFB) with V=3 -> V clamps to 0. `enable`=0 for 3 cycles mid-run -> state frozen, spikes 0.

Source files
------------

// File: rtl/snn_delay_layer_pkg.sv
// Shared constants and arithmetic helpers for the spiking delay layer.
// Build option: SNN_SIGNED_WEIGHTS_EN (signed weights, consumed by snn_lif_neuron).
package snn_pkg;

  localparam int SNN_PW_DEFAULT = 8;
  localparam int SNN_DW_DEFAULT = 3;
  localparam int SNN_ACC_MAX    = 32;

  // Accumulator width: potential plus M weights, plus a sign bit and one guard bit.
  function automatic int snn_acc_width(input int pw, input int m);
    return pw + $clog2(m) + 2;
  endfunction

  function automatic logic [SNN_ACC_MAX-1:0] snn_clamp(
    input logic signed [SNN_ACC_MAX-1:0] acc,
    input int                            pw
  );
    logic signed [SNN_ACC_MAX-1:0] hi;
    hi = $signed((32'd1 << pw) - 32'd1);
    if (acc < 0)       return '0;
    else if (acc > hi) return hi;
    else               return acc;
  endfunction

endpackage

// File: rtl/snn_delay_layer_if.sv
// Bundle of the layer's control, configuration and result signals; clk/reset stay separate.
interface snn_delay_layer_if #(
  parameter int M  = 16,
  parameter int N  = 8,
  parameter int DW = 3,
  parameter int PW = 8
);
  logic              enable;
  logic              delay_tick;
  logic [M-1:0]      input_spikes;
  logic [N*M*PW-1:0] weights;
  logic [N*M*DW-1:0] delay_values;
  logic [N*M-1:0]    delays_en;
  logic [PW-1:0]     threshold;
  logic [PW-1:0]     decay;
  logic [PW-1:0]     refractory_period;
  logic [N*PW-1:0]   membrane_potential_out;
  logic [N-1:0]      output_spikes;

  modport master (
    output enable, delay_tick, input_spikes, weights, delay_values, delays_en,
           threshold, decay, refractory_period,
    input  membrane_potential_out, output_spikes
  );

  modport slave (
    input  enable, delay_tick, input_spikes, weights, delay_values, delays_en,
           threshold, decay, refractory_period,
    output membrane_potential_out, output_spikes
  );
endinterface

// File: rtl/snn_delay_layer_lif_neuron.sv
// One leaky-integrate-and-fire neuron: owns potential, refractory counter and spike register.
// Build option: SNN_SIGNED_WEIGHTS_EN selects two's-complement weights.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int M  = 16,
  parameter int PW = SNN_PW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  input  logic [M-1:0]    spikes_i,
  input  logic [M*PW-1:0] weights_i,
  input  logic [PW-1:0]   threshold_i,
  input  logic [PW-1:0]   decay_i,
  input  logic [PW-1:0]   refractory_i,
  output logic [PW-1:0]   v_o,
  output logic            spike_o
);

  localparam int AW = snn_acc_width(PW, M);

  logic [PW-1:0]        v_q, v_d;
  logic [PW-1:0]        r_q, r_d;
  logic                 spike_q, spike_d;
  logic signed [AW-1:0] acc;
  logic [PW-1:0]        clamped;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    acc = $signed(AW'(v_q)) - $signed(AW'(decay_i));
    for (int m = 0; m < M; m++) begin
      if (spikes_i[m]) begin
`ifdef SNN_SIGNED_WEIGHTS_EN
        acc = acc + AW'($signed(weights_i[m*PW +: PW]));
`else
        acc = acc + $signed(AW'(weights_i[m*PW +: PW]));
`endif
      end
    end
    clamped = PW'(snn_clamp(SNN_ACC_MAX'(acc), PW));

    v_d     = v_q;
    r_d     = r_q;
    spike_d = 1'b0;
    if (enable_i) begin
      if (r_q != '0) begin
        r_d = r_q - PW'(1);
        v_d = '0;
      end else if (clamped >= threshold_i) begin
        spike_d = 1'b1;
        v_d     = '0;
        r_d     = refractory_i;
      end else begin
        v_d = clamped;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all neurons update in lockstep.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      r_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      r_q     <= r_d;
      spike_q <= spike_d;
    end
  end

  assign v_o     = v_q;
  assign spike_o = spike_q;

endmodule

// File: rtl/snn_delay_layer.sv
// LIF spiking layer with per-synapse axonal delay taps; top owns the spike history.
// Build option: SNN_SIGNED_WEIGHTS_EN (signed weights inside each neuron).
module snn_delay_layer
  import snn_pkg::*;
#(
  parameter int M  = 16,
  parameter int N  = 8,
  parameter int DW = SNN_DW_DEFAULT,
  parameter int PW = SNN_PW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              delay_tick,
  input  logic [M-1:0]      input_spikes,
  input  logic [N*M*PW-1:0] weights,
  input  logic [N*M*DW-1:0] delay_values,
  input  logic [N*M-1:0]    delays_en,
  input  logic [PW-1:0]     threshold,
  input  logic [PW-1:0]     decay,
  input  logic [PW-1:0]     refractory_period,
  output logic [N*PW-1:0]   membrane_potential_out,
  output logic [N-1:0]      output_spikes
);

  localparam int DEPTH = (1 << DW) - 1;

  logic [M-1:0] hist_q [1:DEPTH];
  logic [M-1:0] hist_d [1:DEPTH];
  logic [M-1:0] taps   [0:DEPTH];

  always_comb begin
    hist_d = hist_q;
    if (enable && delay_tick) begin
      hist_d[1] = input_spikes;
      for (int k = 2; k <= DEPTH; k++) hist_d[k] = hist_q[k-1];
    end
  end

  // NOTE: the history is a short register array, so it is cleared on reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) hist_q[k] <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Tap 0 is the live input, so a zero delay with the tap selected is just undelayed.
  always_comb begin
    taps[0] = input_spikes;
    for (int k = 1; k <= DEPTH; k++) taps[k] = hist_q[k];
  end

  for (genvar n = 0; n < N; n++) begin : g_neuron
    logic [M-1:0]  eff;
    logic [DW-1:0] dsel;

    always_comb begin
      eff  = '0;
      dsel = '0;
      for (int m = 0; m < M; m++) begin
        dsel   = delay_values[(n*M+m)*DW +: DW];
        eff[m] = delays_en[n*M+m] ? taps[dsel][m] : input_spikes[m];
      end
    end

    snn_lif_neuron #(.M(M), .PW(PW)) u_neuron (
      .clk          (clk),
      .reset        (reset),
      .enable_i     (enable),
      .spikes_i     (eff),
      .weights_i    (weights[n*M*PW +: M*PW]),
      .threshold_i  (threshold),
      .decay_i      (decay),
      .refractory_i (refractory_period),
      .v_o          (membrane_potential_out[n*PW +: PW]),
      .spike_o      (output_spikes[n])
    );
  end

endmodule

// File: tb/tb_snn_delay_layer.sv
// Scenario bench for snn_delay_layer: expectations queued with stimulus, compared after each edge.
module tb_snn_delay_layer;

  localparam int M  = 16;
  localparam int N  = 8;
  localparam int DW = 3;
  localparam int PW = 8;

  typedef struct {
    string      tag;
    int         n;
    logic [7:0] v;
    logic       spk;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  snn_delay_layer_if #(.M(M), .N(N), .DW(DW), .PW(PW)) bus ();

  snn_delay_layer #(.M(M), .N(N), .DW(DW), .PW(PW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (bus.enable),
    .delay_tick             (bus.delay_tick),
    .input_spikes           (bus.input_spikes),
    .weights                (bus.weights),
    .delay_values           (bus.delay_values),
    .delays_en              (bus.delays_en),
    .threshold              (bus.threshold),
    .decay                  (bus.decay),
    .refractory_period      (bus.refractory_period),
    .membrane_potential_out (bus.membrane_potential_out),
    .output_spikes          (bus.output_spikes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_n(input string tag, input int n, input logic [7:0] v, input logic spk);
    sb.push_back('{tag: tag, n: n, v: v, spk: spk});
  endtask

  task automatic expect_all(input string tag, input logic [7:0] v, input logic spk);
    for (int n = 0; n < N; n++) expect_n(tag, n, v, spk);
  endtask

  // Advance one edge, then retire every queued expectation against the settled outputs.
  task automatic step();
    exp_t       e;
    logic [7:0] av;
    logic       as;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      av = bus.membrane_potential_out[e.n*PW +: PW];
      as = bus.output_spikes[e.n];
      checks++;
      if (av !== e.v || as !== e.spk) begin
        errors++;
        $display("FAIL %s n%0d: got V=%0d spk=%b, want V=%0d spk=%b", e.tag, e.n, av, as, e.v, e.spk);
      end
    end
  endtask

  task automatic set_w(input int n, input int m, input logic [7:0] w);
    bus.weights[(n*M+m)*PW +: PW] = w;
  endtask

  task automatic clear_cfg();
    bus.enable            = 1'b0;
    bus.delay_tick        = 1'b0;
    bus.input_spikes      = '0;
    bus.weights           = '0;
    bus.delay_values      = '0;
    bus.delays_en         = '0;
    bus.threshold         = 8'd255;
    bus.decay             = '0;
    bus.refractory_period = '0;
  endtask

  task automatic do_reset();
    clear_cfg();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_cfg();
    reset = 1'b1;
    step();
    expect_all("reset", 8'd0, 1'b0);
    step();
    reset      = 1'b0;
    bus.enable = 1'b1;
    bus.decay  = 8'd1;
    expect_all("idle_decay", 8'd0, 1'b0);
    step();
    expect_all("idle_decay2", 8'd0, 1'b0);
    step();
  endtask

  task automatic test_undelayed();
    do_reset();
    bus.enable          = 1'b1;
    bus.threshold       = 8'd10;
    set_w(0, 0, 8'd4);
    bus.input_spikes[0] = 1'b1;
    expect_n("integ_4", 0, 8'd4, 1'b0);  step();
    expect_n("integ_8", 0, 8'd8, 1'b0);  step();
    expect_n("integ_fire", 0, 8'd0, 1'b1);
    expect_n("integ_other", 1, 8'd0, 1'b0);
    step();
    expect_n("integ_restart", 0, 8'd4, 1'b0); step();
    bus.enable = 1'b0;
    repeat (3) begin
      expect_n("freeze", 0, 8'd4, 1'b0);
      step();
    end
    bus.enable = 1'b1;
    expect_n("thaw", 0, 8'd8, 1'b0); step();
    bus.enable = 1'b0;
    expect_n("freeze_before_fire", 0, 8'd8, 1'b0); step();
    bus.enable = 1'b1;
    expect_n("fire_after_thaw", 0, 8'd0, 1'b1); step();
    bus.input_spikes = '0;
  endtask

  task automatic test_delay();
    do_reset();
    bus.enable     = 1'b1;
    bus.delay_tick = 1'b1;
    bus.threshold  = 8'd15;
    set_w(1, 2, 8'd20);
    bus.delays_en[1*M+2]                 = 1'b1;
    bus.delay_values[(1*M+2)*DW +: DW]   = 3'd3;
    bus.input_spikes[2] = 1'b1;
    expect_n("delay_t0", 1, 8'd0, 1'b0);
    step();
    bus.input_spikes[2] = 1'b0;
    expect_n("delay_t1", 1, 8'd0, 1'b0); step();
    expect_n("delay_t2", 1, 8'd0, 1'b0); step();
    expect_n("delay_fire", 1, 8'd0, 1'b1);
    expect_n("delay_n0_quiet", 0, 8'd0, 1'b0);
    step();
    expect_n("delay_once_a", 1, 8'd0, 1'b0); step();
    expect_n("delay_once_b", 1, 8'd0, 1'b0); step();
  endtask

  task automatic test_refractory();
    do_reset();
    bus.enable            = 1'b1;
    bus.threshold         = 8'd10;
    bus.refractory_period = 8'd2;
    set_w(0, 0, 8'd4);
    bus.input_spikes[0] = 1'b1;
    expect_n("refr_4", 0, 8'd4, 1'b0);    step();
    expect_n("refr_8", 0, 8'd8, 1'b0);    step();
    expect_n("refr_fire", 0, 8'd0, 1'b1); step();
    expect_n("refr_hold1", 0, 8'd0, 1'b0); step();
    expect_n("refr_hold2", 0, 8'd0, 1'b0); step();
    expect_n("refr_resume", 0, 8'd4, 1'b0); step();
    expect_n("refr_resume8", 0, 8'd8, 1'b0); step();
    expect_n("refr_refire", 0, 8'd0, 1'b1); step();
    bus.input_spikes = '0;
  endtask

  task automatic test_saturation_decay();
    do_reset();
    bus.enable    = 1'b1;
    bus.threshold = 8'd255;
    set_w(0, 0, 8'd200);
    set_w(0, 1, 8'd200);
    bus.input_spikes[1:0] = 2'b11;
    // 400 saturates to 255 and reaches the threshold; a wrapped sum (144) would not.
    expect_n("sat_fire", 0, 8'd0, 1'b1); step();
    set_w(0, 0, 8'd254);
    bus.input_spikes = 16'h0001;
    expect_n("sat_load", 0, 8'd254, 1'b0); step();
    bus.input_spikes = '0;
    bus.decay        = 8'd100;
    expect_n("decay_154", 0, 8'd154, 1'b0); step();
    expect_n("decay_54", 0, 8'd54, 1'b0);   step();
    expect_n("decay_0", 0, 8'd0, 1'b0);     step();
    expect_n("decay_0b", 0, 8'd0, 1'b0);    step();
  endtask

  task automatic test_weight_sign();
    do_reset();
    bus.enable    = 1'b1;
    bus.threshold = 8'd255;
    set_w(0, 0, 8'd3);
    set_w(0, 1, 8'hFB);
    bus.input_spikes = 16'h0001;
    expect_n("sign_base", 0, 8'd3, 1'b0); step();
    bus.input_spikes = 16'h0002;
`ifdef SNN_SIGNED_WEIGHTS_EN
    expect_n("sign_neg_clamp", 0, 8'd0, 1'b0);
`else
    expect_n("unsigned_add", 0, 8'd254, 1'b0);
`endif
    step();
    bus.input_spikes = '0;
  endtask

  task automatic test_threshold_zero();
    do_reset();
    bus.enable    = 1'b1;
    bus.threshold = 8'd0;
    expect_all("thr0_a", 8'd0, 1'b1); step();
    expect_all("thr0_b", 8'd0, 1'b1); step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.enable    = 1'b1;
    bus.threshold = 8'd255;
    set_w(0, 0, 8'd50);
    bus.input_spikes = 16'h0001;
    expect_n("mid_50", 0, 8'd50, 1'b0);  step();
    expect_n("mid_100", 0, 8'd100, 1'b0); step();
    reset = 1'b1;
    expect_all("mid_reset", 8'd0, 1'b0); step();
    reset = 1'b0;
    expect_n("mid_after", 0, 8'd50, 1'b0); step();
    bus.input_spikes = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_cfg();
    test_reset();
    test_undelayed();
    test_delay();
    test_refractory();
    test_saturation_decay();
    test_weight_sign();
    test_threshold_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
